vga_timing_gen: RTL and testbench

//  Upstream raster stage of the character-terminal display path. Counts pixel/line position on disp_clock and

---
 rtl/vga_timing_gen_pkg.sv | 40 ++++
 rtl/vga_timing_gen_sig_delay_line.sv | 43 ++++
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared raster definitions for the VGA timing generator: 640x480@60 default
// geometry, the per-pixel decode record and small compare helpers.
package vga_timing_gen_pkg;

    localparam int CNT_W = 10;

    localparam int H_VISIBLE_DEF  = 640;
    localparam int H_FRONT_DEF    = 16;
    localparam int H_SYNC_DEF     = 96;
    localparam int H_BACK_DEF     = 48;
    localparam int V_VISIBLE_DEF  = 480;
    localparam int V_FRONT_DEF    = 10;
    localparam int V_SYNC_DEF     = 2;
    localparam int V_BACK_DEF     = 33;
    localparam bit SYNC_POL_DEF   = 1'b0;
    localparam int PIPE_DELAY_DEF = 2;

    // Raster sequencing: idle parks at the origin, run advances one pixel per clock.
    typedef enum logic {
        RASTER_IDLE = 1'b0,
        RASTER_RUN  = 1'b1
    } raster_state_t;

    // Everything decoded from one (h_pos, v_pos) pair.
    typedef struct packed {
        logic valid_draw;
        logic v_blank;
        logic frame_start;
        logic h_sync;
        logic v_sync;
    } raster_dec_t;

    // Half-open window test lo <= val < hi; one spare bit so a 1024 bound still compares correctly.
    function automatic logic in_window(input logic [CNT_W:0] val,
                                       input logic [CNT_W:0] lo,
                                       input logic [CNT_W:0] hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_sig_delay_line.sv
// Resettable WIDTH-bit shift register used to line sync/blank strobes up with
// the colour pipeline. DEPTH=0 degenerates to a plain wire.
module sig_delay_line #(
    parameter int              WIDTH   = 1,
    parameter int              DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift one stage per clock; both resets load the idle value into every stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RST_VAL;
                    end
                end else if (srst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= RST_VAL;
                    end
                end else begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign q = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counter and timing decode for the character-terminal display path.
// Position and decodes are registered together so every decode describes the
// h_pos/v_pos presented in the same cycle; VGA strobes trail by PIPE_DELAY.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int H_VISIBLE  = H_VISIBLE_DEF,
    parameter int H_FRONT    = H_FRONT_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BACK     = H_BACK_DEF,
    parameter int V_VISIBLE  = V_VISIBLE_DEF,
    parameter int V_FRONT    = V_FRONT_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BACK     = V_BACK_DEF,
    parameter bit SYNC_POL   = SYNC_POL_DEF,
    parameter int PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic             disp_clock,
    input  logic             reset_n,
    input  logic             en,
    output logic [CNT_W-1:0] h_pos,
    output logic [CNT_W-1:0] v_pos,
    output logic             valid_draw,
    output logic             v_blank,
    output logic             frame_start,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n,
    output logic             vga_sync_n
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    localparam logic [CNT_W:0] H_VIS_L = (CNT_W+1)'(H_VISIBLE);
    localparam logic [CNT_W:0] HS_LO   = (CNT_W+1)'(H_VISIBLE + H_FRONT);
    localparam logic [CNT_W:0] HS_HI   = (CNT_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [CNT_W:0] V_VIS_L = (CNT_W+1)'(V_VISIBLE);
    localparam logic [CNT_W:0] VS_LO   = (CNT_W+1)'(V_VISIBLE + V_FRONT);
    localparam logic [CNT_W:0] VS_HI   = (CNT_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    localparam raster_dec_t DEC_IDLE = '{
        valid_draw:  1'b0,
        v_blank:     1'b0,
        frame_start: 1'b0,
        h_sync:      ~SYNC_POL,
        v_sync:      ~SYNC_POL
    };

    raster_state_t    state_r;
    logic [CNT_W-1:0] h_r;
    logic [CNT_W-1:0] v_r;
    raster_dec_t      dec_r;

    logic [CNT_W-1:0] h_nxt_s;
    logic [CNT_W-1:0] v_nxt_s;
    raster_dec_t      dec_nxt_s;
    logic [2:0]       vga_dly_s;

    // Next raster position: idle restarts at the origin, run advances with line/frame wrap.
    always_comb begin
        h_nxt_s = '0;
        v_nxt_s = '0;
        case (state_r)
            RASTER_IDLE: begin
                h_nxt_s = '0;
                v_nxt_s = '0;
            end
            RASTER_RUN: begin
                if (h_r == H_LAST) begin
                    h_nxt_s = '0;
                    if (v_r == V_LAST) begin
                        v_nxt_s = '0;
                    end else begin
                        v_nxt_s = v_r + 10'd1;
                    end
                end else begin
                    h_nxt_s = h_r + 10'd1;
                    v_nxt_s = v_r;
                end
            end
            default: begin
                h_nxt_s = '0;
                v_nxt_s = '0;
            end
        endcase
    end

    // Decode the position about to be registered so decodes and counters stay coincident.
    always_comb begin
        dec_nxt_s             = DEC_IDLE;
        dec_nxt_s.valid_draw  = ({1'b0, h_nxt_s} < H_VIS_L) && ({1'b0, v_nxt_s} < V_VIS_L);
        dec_nxt_s.v_blank     = ({1'b0, v_nxt_s} >= V_VIS_L);
        dec_nxt_s.frame_start = (h_nxt_s == 10'd0) && (v_nxt_s == 10'd0);
        dec_nxt_s.h_sync      = in_window({1'b0, h_nxt_s}, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
        dec_nxt_s.v_sync      = in_window({1'b0, v_nxt_s}, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
    end

    // Raster state, counters and decodes; en low parks everything at the idle origin.
    always_ff @(posedge disp_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RASTER_IDLE;
            h_r     <= '0;
            v_r     <= '0;
            dec_r   <= DEC_IDLE;
        end else if (!en) begin
            state_r <= RASTER_IDLE;
            h_r     <= '0;
            v_r     <= '0;
            dec_r   <= DEC_IDLE;
        end else begin
            state_r <= RASTER_RUN;
            h_r     <= h_nxt_s;
            v_r     <= v_nxt_s;
            dec_r   <= dec_nxt_s;
        end
    end

    // The delay line keeps shifting while parked, so it drains to idle on its own.
    sig_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
    ) u_vga_dly (
        .clk   (disp_clock),
        .rst_n (reset_n),
        .srst  (1'b0),
        .d     ({dec_r.h_sync, dec_r.v_sync, dec_r.valid_draw}),
        .q     (vga_dly_s)
    );

    assign h_pos       = h_r;
    assign v_pos       = v_r;
    assign valid_draw  = dec_r.valid_draw;
    assign v_blank     = dec_r.v_blank;
    assign frame_start = dec_r.frame_start;
    assign {vga_hs, vga_vs, vga_blank_n} = vga_dly_s;
    // No sync-on-green on this board.
    assign vga_sync_n  = 1'b1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: one full-size 640x480 instance (delay 2)
// and two reduced-geometry instances (16x11 raster, delay 0 and delay 4 with
// active-high syncs) so that frame wraps fit in a short run.
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    logic en;

    logic [9:0] h_a, v_a, h_b, v_b, h_c, v_c;
    logic vd_a, vb_a, fs_a, hs_a, vs_a, bn_a, sn_a;
    logic vd_b, vb_b, fs_b, hs_b, vs_b, bn_b, sn_b;
    logic vd_c, vb_c, fs_c, hs_c, vs_c, bn_c, sn_c;

    int n_checks;
    int n_errors;

    // Model: p = cycles since the raster started (-1 while idle/reset), kept per cycle g.
    int p;
    int g;
    int p_hist [65536];

    // Geometry per instance: 0 = full size, 1 = small delay 0, 2 = small delay 4.
    int   ht   [3] = '{800, 16, 16};
    int   vt   [3] = '{525, 11, 11};
    int   hvis [3] = '{640, 8, 8};
    int   vvis [3] = '{480, 6, 6};
    int   hslo [3] = '{656, 10, 10};
    int   hshi [3] = '{752, 13, 13};
    int   vslo [3] = '{490, 8, 8};
    int   vshi [3] = '{492, 9, 9};
    int   pd   [3] = '{2, 0, 4};
    logic pol  [3] = '{1'b0, 1'b0, 1'b1};

    vga_timing_gen u_dut_a (
        .disp_clock(clk), .reset_n(rst_n), .en(en),
        .h_pos(h_a), .v_pos(v_a), .valid_draw(vd_a), .v_blank(vb_a), .frame_start(fs_a),
        .vga_hs(hs_a), .vga_vs(vs_a), .vga_blank_n(bn_a), .vga_sync_n(sn_a)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(1), .V_BACK(2),
        .SYNC_POL(1'b0), .PIPE_DELAY(0)
    ) u_dut_b (
        .disp_clock(clk), .reset_n(rst_n), .en(en),
        .h_pos(h_b), .v_pos(v_b), .valid_draw(vd_b), .v_blank(vb_b), .frame_start(fs_b),
        .vga_hs(hs_b), .vga_vs(vs_b), .vga_blank_n(bn_b), .vga_sync_n(sn_b)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(1), .V_BACK(2),
        .SYNC_POL(1'b1), .PIPE_DELAY(4)
    ) u_dut_c (
        .disp_clock(clk), .reset_n(rst_n), .en(en),
        .h_pos(h_c), .v_pos(v_c), .valid_draw(vd_c), .v_blank(vb_c), .frame_start(fs_c),
        .vga_hs(hs_c), .vga_vs(vs_c), .vga_blank_n(bn_c), .vga_sync_n(sn_c)
    );

    // Pixel clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected undelayed outputs for an instance at raster step p.
    task automatic model(input int d, input int pp,
                         output logic [9:0] eh, output logic [9:0] ev,
                         output logic evd, output logic evb, output logic efs,
                         output logic ehs, output logic evs);
        int hh;
        int vv;
        if (pp < 0) begin
            eh = 10'd0; ev = 10'd0; evd = 1'b0; evb = 1'b0; efs = 1'b0;
            ehs = ~pol[d]; evs = ~pol[d];
        end else begin
            hh  = pp % ht[d];
            vv  = (pp / ht[d]) % vt[d];
            eh  = 10'(hh);
            ev  = 10'(vv);
            evd = (hh < hvis[d]) && (vv < vvis[d]);
            evb = (vv >= vvis[d]);
            efs = (hh == 0) && (vv == 0);
            ehs = (hh >= hslo[d] && hh < hshi[d]) ? pol[d] : ~pol[d];
            evs = (vv >= vslo[d] && vv < vshi[d]) ? pol[d] : ~pol[d];
        end
    endtask

    task automatic check_dut(input string nm, input int d,
                             input logic [9:0] hp, input logic [9:0] vp,
                             input logic vd, input logic vb, input logic fs,
                             input logic hs, input logic vs, input logic bn, input logic sn);
        logic [9:0] eh, ev, dh, dv;
        logic evd, evb, efs, ehs, evs;
        logic dvd, dvb, dfs, dhs, dvs;
        model(d, p_hist[g], eh, ev, evd, evb, efs, ehs, evs);
        model(d, p_hist[g - pd[d]], dh, dv, dvd, dvb, dfs, dhs, dvs);
        chk({nm, ".h_pos"}, 32'(hp), 32'(eh));
        chk({nm, ".v_pos"}, 32'(vp), 32'(ev));
        chk({nm, ".valid_draw"}, 32'(vd), 32'(evd));
        chk({nm, ".v_blank"}, 32'(vb), 32'(evb));
        chk({nm, ".frame_start"}, 32'(fs), 32'(efs));
        chk({nm, ".vga_hs"}, 32'(hs), 32'(dhs));
        chk({nm, ".vga_vs"}, 32'(vs), 32'(dvs));
        chk({nm, ".vga_blank_n"}, 32'(bn), 32'(dvd));
        chk({nm, ".vga_sync_n"}, 32'(sn), 32'd1);
    endtask

    task automatic check_all();
        check_dut("a", 0, h_a, v_a, vd_a, vb_a, fs_a, hs_a, vs_a, bn_a, sn_a);
        check_dut("b", 1, h_b, v_b, vd_b, vb_b, fs_b, hs_b, vs_b, bn_b, sn_b);
        check_dut("c", 2, h_c, v_c, vd_c, vb_c, fs_c, hs_c, vs_c, bn_c, sn_c);
    endtask

    // One clock: advance the model on the edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            p = -1;
        end else if (en) begin
            p = (p < 0) ? 0 : p + 1;
        end else begin
            p = -1;
        end
        g++;
        p_hist[g] = p;
        #1;
        check_all();
    endtask

    initial begin
        int hs_low;
        int g0;
        logic found;

        clk      = 1'b0;
        rst_n    = 1'b0;
        en       = 1'b1;
        n_checks = 0;
        n_errors = 0;
        p        = -1;
        g        = 8;
        for (int i = 0; i < 65536; i++) begin
            p_hist[i] = -1;
        end

        // Reset held with en high.
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("rst.a_hs", 32'(hs_a), 32'd1);
        chk("rst.a_vs", 32'(vs_a), 32'd1);
        chk("rst.a_blank_n", 32'(bn_a), 32'd0);
        chk("rst.c_hs", 32'(hs_c), 32'd0);

        // Run through two full-size lines with directed boundary points.
        rst_n  = 1'b1;
        hs_low = 0;
        while (p < 1764) begin
            tick();
            if (p >= 0 && p < 800 && hs_a == 1'b0) begin
                hs_low++;
            end
            case (p)
                0: begin
                    chk("start.a_fs", 32'(fs_a), 32'd1);
                    chk("start.a_valid", 32'(vd_a), 32'd1);
                end
                175: begin
                    chk("bwrap.h", 32'(h_b), 32'd15);
                    chk("bwrap.v", 32'(v_b), 32'd10);
                    chk("bwrap.vblank", 32'(vb_b), 32'd1);
                end
                176: begin
                    chk("bwrap.h0", 32'(h_b), 32'd0);
                    chk("bwrap.v0", 32'(v_b), 32'd0);
                    chk("bwrap.fs", 32'(fs_b), 32'd1);
                    chk("bwrap.vblank0", 32'(vb_b), 32'd0);
                end
                639: chk("a.valid@639", 32'(vd_a), 32'd1);
                640: chk("a.valid@640", 32'(vd_a), 32'd0);
                641: chk("a.blank_n@641", 32'(bn_a), 32'd1);
                642: chk("a.blank_n@642", 32'(bn_a), 32'd0);
                657: chk("a.hs@657", 32'(hs_a), 32'd1);
                658: chk("a.hs@658", 32'(hs_a), 32'd0);
                753: chk("a.hs@753", 32'(hs_a), 32'd0);
                754: chk("a.hs@754", 32'(hs_a), 32'd1);
                799: begin
                    chk("a.h@799", 32'(h_a), 32'd799);
                    chk("a.v@799", 32'(v_a), 32'd0);
                end
                800: begin
                    chk("a.h@800", 32'(h_a), 32'd0);
                    chk("a.v@800", 32'(v_a), 32'd1);
                    chk("a.valid@800", 32'(vd_a), 32'd1);
                end
                default: ;
            endcase
        end
        chk("a.hs_low_cycles", 32'(hs_low), 32'd96);

        // Drop en mid-line at (164,2); strobes drain over the delay depth.
        en = 1'b0;
        tick();
        chk("drop.a_h", 32'(h_a), 32'd0);
        chk("drop.a_v", 32'(v_a), 32'd0);
        chk("drop.a_hs", 32'(hs_a), 32'd1);
        chk("drop.a_valid", 32'(vd_a), 32'd0);
        chk("drop.a_blank_n_lag", 32'(bn_a), 32'd1);
        chk("drop.b_blank_n", 32'(bn_b), 32'd0);
        tick();
        tick();
        chk("drop.a_blank_n_idle", 32'(bn_a), 32'd0);
        tick();
        chk("drop.c_blank_n_lag", 32'(bn_c), 32'd1);
        tick();
        chk("drop.c_blank_n_idle", 32'(bn_c), 32'd0);

        // Re-enable: origin presented with frame_start.
        en = 1'b1;
        tick();
        chk("reen.a_fs", 32'(fs_a), 32'd1);
        chk("reen.a_h", 32'(h_a), 32'd0);
        chk("reen.a_valid", 32'(vd_a), 32'd1);
        chk("reen.b_fs", 32'(fs_b), 32'd1);

        // Run to (123,45) and pulse reset between edges.
        while (p < 36123) begin
            tick();
        end
        chk("mid.a_h", 32'(h_a), 32'd123);
        chk("mid.a_v", 32'(v_a), 32'd45);
        #2;
        rst_n = 1'b0;
        p     = -1;
        for (int i = 0; i < 8; i++) begin
            p_hist[g - i] = -1;
        end
        #1;
        chk("arst.a_h", 32'(h_a), 32'd0);
        chk("arst.a_v", 32'(v_a), 32'd0);
        chk("arst.a_blank_n", 32'(bn_a), 32'd0);
        chk("arst.c_hs", 32'(hs_c), 32'd0);
        check_all();
        tick();
        tick();

        // Frame period on the small raster: 16 x 11 = 176 cycles between frame_start pulses.
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (fs_b) found = 1'b1;
        end
        chk("period.first_fs", 32'(found), 32'd1);
        g0    = g;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (fs_b) found = 1'b1;
        end
        chk("period.second_fs", 32'(found), 32'd1);
        chk("period.cycles", 32'(g - g0), 32'd176);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
